// File: rtl/decode_execute_unit_pkg.sv
// Shared RV32I decode definitions: ALU command set, opcode and funct7 constants,
// plus the SYSTEM encodings that are legal but not executed by this slice.
package common;

  typedef enum logic [3:0] {
    ALU_NOP,
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_cmd;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

package riscv_instr;

  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ECALL  = 32'h0000_0073;

endpackage

// File: rtl/decode_execute_unit_decoder.sv
// Instruction decode: operand select, ALU command, illegal detection and the
// sticky illegal flag (the only clocked state in the slice).
module decoder
  import common::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] regfile [32],
  input  logic [31:0] pc,
  output alu_cmd      alu_ops,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic        illegal,
  output logic        illegal_seen
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] i_imm;
  logic [31:0] u_imm;
  alu_cmd      f3_cmd;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign funct7 = instruction[31:25];

  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : regfile[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : regfile[rs2];
  assign i_imm   = {{20{instruction[31]}}, instruction[31:20]};
  assign u_imm   = {instruction[31:12], 12'b0};

  // Base funct3 map; funct7 qualification is applied per opcode below.
  always_comb begin
    f3_cmd = ALU_NOP;
    case (funct3)
      3'b000:  f3_cmd = ALU_ADD;
      3'b001:  f3_cmd = ALU_SLL;
      3'b010:  f3_cmd = ALU_SLT;
      3'b011:  f3_cmd = ALU_SLTU;
      3'b100:  f3_cmd = ALU_XOR;
      3'b101:  f3_cmd = ALU_SRL;
      3'b110:  f3_cmd = ALU_OR;
      default: f3_cmd = ALU_AND;
    endcase
  end

  always_comb begin
    alu_ops = ALU_NOP;
    op1     = 32'h0;
    op2     = 32'h0;
    illegal = 1'b0;
    case (opcode)
      OP: begin
        op1 = rs1_val;
        op2 = rs2_val;
        if (funct7 == F7_BASE)
          alu_ops = f3_cmd;
        else if (funct7 == F7_ALT && funct3 == 3'b000)
          alu_ops = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101)
          alu_ops = ALU_SRA;
        else
          illegal = 1'b1;
      end
      OP_IMM: begin
        op1 = rs1_val;
        op2 = i_imm;
        // Only shifts carry funct7; elsewhere those bits are immediate.
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (funct7 == F7_BASE)
            alu_ops = f3_cmd;
          else if (funct7 == F7_ALT && funct3 == 3'b101)
            alu_ops = ALU_SRA;
          else
            illegal = 1'b1;
        end else begin
          alu_ops = f3_cmd;
        end
      end
      LUI: begin
        alu_ops = ALU_ADD;
        op2     = u_imm;
      end
      AUIPC: begin
        alu_ops = ALU_ADD;
        op1     = pc;
        op2     = u_imm;
      end
      LOAD, STORE, BRANCH, JAL, JALR, FENCE: illegal = 1'b0;
      SYSTEM: illegal = !(instruction == riscv_instr::EBREAK ||
                          instruction == riscv_instr::ECALL);
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      illegal_seen <= 1'b0;
    else
      illegal_seen <= illegal_seen | illegal;
  end

endmodule

// File: rtl/decode_execute_unit_execute.sv
// Purely combinational RV32I ALU.
module execute
  import common::*;
(
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  alu_cmd      alu_ops,
  output logic [31:0] alu_out
);

  logic [4:0] shamt;
  assign shamt = op2[4:0];

  always_comb begin
    alu_out = 32'h0;
    case (alu_ops)
      ALU_ADD:  alu_out = op1 + op2;
      ALU_SUB:  alu_out = op1 - op2;
      ALU_SLL:  alu_out = op1 << shamt;
      ALU_SLT:  alu_out = ($signed(op1) < $signed(op2)) ? 32'h1 : 32'h0;
      ALU_SLTU: alu_out = (op1 < op2) ? 32'h1 : 32'h0;
      ALU_XOR:  alu_out = op1 ^ op2;
      ALU_SRL:  alu_out = op1 >> shamt;
      ALU_SRA:  alu_out = $unsigned($signed(op1) >>> shamt);
      ALU_OR:   alu_out = op1 | op2;
      ALU_AND:  alu_out = op1 & op2;
      default:  alu_out = 32'h0;
    endcase
  end

endmodule

// File: rtl/decode_execute_unit.sv
// RV32I decode + ALU slice of the single-cycle core; alu_out is written back
// to rd by the core at the next clock edge.
module decode_execute_unit
  import common::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] regfile [32],
  input  logic [XLEN-1:0] pc,
  output alu_cmd          alu_ops,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] alu_out,
  output logic            illegal,
  output logic            illegal_seen
);

  decoder u_decoder (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .regfile      (regfile),
    .pc           (pc),
    .alu_ops      (alu_ops),
    .op1          (op1),
    .op2          (op2),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  execute u_execute (
    .op1     (op1),
    .op2     (op2),
    .alu_ops (alu_ops),
    .alu_out (alu_out)
  );

endmodule

// File: tb/tb_decode_execute_unit.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// samples the DUT on the falling edge and compares.
module tb_decode_execute_unit;
  import common::*;

  typedef struct {
    string       name;
    bit          chk_alu;
    bit          chk_ill;
    bit          chk_seen;
    alu_cmd      ops;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic        ill;
    logic        seen;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = 32'h0000_0013;
  logic [31:0] regfile [32];
  logic [31:0] pc = 32'h0;
  alu_cmd      alu_ops;
  logic [31:0] op1, op2, alu_out;
  logic        illegal, illegal_seen;

  exp_t q[$];
  bit   stim_done = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic exp_seen = 1'b0;

  decode_execute_unit #(.XLEN(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .regfile      (regfile),
    .pc           (pc),
    .alu_ops      (alu_ops),
    .op1          (op1),
    .op2          (op2),
    .alu_out      (alu_out),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  always #5 clock = ~clock;

  task automatic cmp(input string nm, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, field, act, exp);
    end
  endtask

  // Drive one vector after the rising edge and queue what it must produce.
  task automatic issue(input string nm, input logic [31:0] instr,
                       input bit ca, input alu_cmd c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r,
                       input bit ci, input logic il);
    exp_t e;
    @(posedge clock);
    #1;
    instruction = instr;
    e.name = nm; e.chk_alu = ca; e.chk_ill = ci; e.chk_seen = 1'b1;
    e.ops = c; e.op1 = a; e.op2 = b; e.res = r; e.ill = il;
    e.seen = exp_seen;
    q.push_back(e);
    if (reset && il && ci) exp_seen = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regfile[i] = 32'h0;
    regfile[0] = 32'hDEAD_BEEF;

    // In reset: combinational path still live, flag held low.
    issue("addi_in_reset", 32'hFFF0_0093, 1, ALU_ADD, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
    @(posedge clock); #2; reset = 1'b1;

    issue("addi_x0_garbage", 32'hFFF0_0093, 1, ALU_ADD, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);

    regfile[2] = 32'd5; regfile[3] = 32'd7;
    issue("sub", 32'h4031_00B3, 1, ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1'b0);

    @(posedge clock); #1; regfile[2] = 32'h8000_0000;
    issue("srai", 32'h4041_5093, 1, ALU_SRA, 32'h8000_0000, 32'h0000_0404, 32'hF800_0000, 1, 1'b0);
    issue("srli", 32'h0041_5093, 1, ALU_SRL, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1, 1'b0);

    @(posedge clock); #1; regfile[2] = 32'hFFFF_FFFF; regfile[3] = 32'd1;
    issue("slt",   32'h0031_20B3, 1, ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b0);
    issue("sltu",  32'h0031_30B3, 1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0);
    issue("slti",  32'h0001_2093, 1, ALU_SLT,  32'hFFFF_FFFF, 32'd0, 32'd1, 1, 1'b0);
    issue("sltiu", 32'hFFF1_B093, 1, ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 1'b0);
    issue("add_wrap", 32'h0031_00B3, 1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0);
    issue("sll",   32'h0031_10B3, 1, ALU_SLL, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1, 1'b0);
    issue("xor",   32'h0031_40B3, 1, ALU_XOR, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFE, 1, 1'b0);
    issue("or",    32'h0031_60B3, 1, ALU_OR,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1, 1'b0);
    issue("and",   32'h0031_70B3, 1, ALU_AND, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 1'b0);

    @(posedge clock); #1; pc = 32'h100;
    issue("lui",   32'h1234_50B7, 1, ALU_ADD, 32'h0, 32'h1234_5000, 32'h1234_5000, 1, 1'b0);
    issue("auipc", 32'h0000_1097, 1, ALU_ADD, 32'h100, 32'h0000_1000, 32'h0000_1100, 1, 1'b0);

    issue("ebreak", 32'h0010_0073, 1, ALU_NOP, 32'h0, 32'h0, 32'h0, 1, 1'b0);
    issue("load",   32'h0000_2083, 1, ALU_NOP, 32'h0, 32'h0, 32'h0, 1, 1'b0);

    issue("all_ones", 32'hFFFF_FFFF, 1, ALU_NOP, 32'h0, 32'h0, 32'h0, 1, 1'b1);
    issue("after_illegal", 32'hFFF0_0093, 1, ALU_ADD, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
    issue("mul_illegal", 32'h0231_00B3, 0, ALU_NOP, 32'h0, 32'h0, 32'h0, 1, 1'b1);
    issue("flag_holds", 32'h0000_2083, 1, ALU_NOP, 32'h0, 32'h0, 32'h0, 1, 1'b0);

    // Asynchronous clear: no clock edge between assertion and the sample.
    @(posedge clock); #1;
    reset = 1'b0;
    exp_seen = 1'b0;
    begin
      exp_t e;
      e.name = "async_clear"; e.chk_alu = 0; e.chk_ill = 0; e.chk_seen = 1;
      e.ops = ALU_NOP; e.op1 = 0; e.op2 = 0; e.res = 0; e.ill = 0; e.seen = 1'b0;
      q.push_back(e);
    end
    stim_done = 1'b1;
  end

  initial begin
    int cycles = 0;
    while (!(stim_done && q.size() == 0) && cycles < 500) begin
      @(negedge clock);
      cycles++;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.chk_alu) begin
          cmp(e.name, "alu_ops", 32'(alu_ops), 32'(e.ops));
          cmp(e.name, "op1", op1, e.op1);
          cmp(e.name, "op2", op2, e.op2);
          cmp(e.name, "alu_out", alu_out, e.res);
        end
        if (e.chk_ill)  cmp(e.name, "illegal", 32'(illegal), 32'(e.ill));
        if (e.chk_seen) cmp(e.name, "illegal_seen", 32'(illegal_seen), 32'(e.seen));
      end
    end
    if (!(stim_done && q.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL timeout pending=%0d required=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_execute_unit.md
Name: decode_execute_unit

Overview:
Combinational RV32I integer decode plus ALU slice of the single-cycle core.
- Decodes the current instruction word.
- Reads source operands from the core's register-file array and the current PC.
- Selects op1/op2 and the ALU command, then computes alu_out in the same cycle.
- The core writes alu_out back to rd at the next clock edge.
- The only state is a sticky illegal-instruction flag.

Parameters:
XLEN, 32, datapath width. Only 32 is supported.

Ports:
clock  in  1  system clock; only the sticky flag uses it.
reset  in  1  asynchronous, active-low reset. Port name is "reset"; 0 = in reset.
instruction  in  32  current instruction word.
regfile  in  32x[31:0] unpacked array  architectural registers x0..x31.
pc  in  32  address of the current instruction.
alu_ops  out  common::alu_cmd  decoded ALU command.
op1  out  32  first ALU operand.
op2  out  32  second ALU operand.
alu_out  out  32  ALU result.
illegal  out  1  current instruction is not supported (combinational).
illegal_seen  out  1  sticky: an illegal instruction was decoded since reset.

Behaviour:
- Field extraction: opcode=[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- rs1 and rs2 reads of x0 return 0, whatever regfile[0] holds.
- Immediates are sign-extended to 32 bits.
  - I-imm = inst[31:20].
  - U-imm = {inst[31:12], 12'b0}.
- R-type (0110011):
  - op1 = rs1 value, op2 = rs2 value.
  - funct3/funct7 select the command: 000/0000000 ADD; 000/0100000 SUB; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101/0000000 SRL; 101/0100000 SRA; 110 OR; 111 AND.
  - Any other funct7 value is illegal.
- I-type arithmetic (0010011):
  - op1 = rs1 value, op2 = I-imm.
  - Same funct3 map as R-type, except 000 is always ADD (there is no SUBI).
  - Shifts use op2[4:0] = shamt. funct7 0100000 with funct3 101 selects SRAI; any other nonzero funct7 on a shift is illegal.
- LUI (0110111): op1 = 0, op2 = U-imm, command ADD.
- AUIPC (0010111): op1 = pc, op2 = U-imm, command ADD.
- Any other opcode:
  - alu_ops = NOP, op1 = op2 = 0, alu_out = 0.
  - illegal = 0 for EBREAK/ECALL (0x00100073/0x00000073) and for load, store, branch, JAL, JALR and FENCE opcodes. These are handled elsewhere.
  - illegal = 1 for every remaining opcode.
- ALU rules:
  - ADD/SUB wrap modulo 2^32.
  - Shift amount is op2[4:0].
  - SLT compares signed; SLTU compares unsigned. Both produce 32'h0 or 32'h1.
  - SRA replicates the sign bit.
  - NOP yields 0.
- Latency: every output except illegal_seen is purely combinational, with zero cycles from instruction/regfile/pc.
- illegal_seen:
  - Cleared asynchronously while reset = 0.
  - On a rising clock edge with reset = 1 it captures illegal_seen | illegal.
  - Reset value 0.
- Reset does not affect the combinational outputs; they track their inputs even while in reset.

Decomposition:
- Package common:
  - enum alu_cmd {ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND}.
  - Opcode localparams (OP, OP_IMM, LUI, AUIPC, LOAD, STORE, BRANCH, JAL, JALR, FENCE, SYSTEM).
  - Funct7 constants.
- Package riscv_instr: EBREAK/ECALL encodings.
- Sub-modules:
  - decoder: field/immediate extraction, operand select, illegal detection, sticky flag.
  - execute: pure combinational ALU, (op1, op2, alu_ops) -> alu_out.
  - decode_execute_unit instantiates one of each.

Test Plan:
- Reset and flag:
  - Hold reset = 0, then release. illegal_seen = 0.
  - Apply an illegal word 0xFFFFFFFF for one cycle: illegal = 1; after the next edge illegal_seen = 1 and it stays 1 afterwards.
  - Assert reset = 0 asynchronously: illegal_seen clears immediately.
- ADDI with x0 garbage:
  - regfile[0] = 0xDEADBEEF. Apply addi x1,x0,-1 (0xFFF00093).
  - Expect op1 = 0, op2 = 0xFFFFFFFF, alu_ops = ALU_ADD, alu_out = 0xFFFFFFFF.
- SUB and shifts:
  - x2 = 5, x3 = 7. sub x1,x2,x3 -> alu_out = 0xFFFFFFFE.
  - x2 = 0x80000000. srai x1,x2,4 -> 0xF8000000; srli x1,x2,4 -> 0x08000000.
- Compares:
  - x2 = 0xFFFFFFFF, x3 = 1.
  - slt -> 1; sltu -> 0; slti x1,x2,0 -> 1; sltiu x1,x3,-1 -> 1.
- LUI/AUIPC:
  - pc = 0x100. lui x1,0x12345 -> 0x12345000; auipc x1,0x1 -> 0x00001100.
- Non-ALU opcodes:
  - EBREAK 0x00100073 -> alu_ops = ALU_NOP, alu_out = 0, illegal = 0.
  - Load 0x00002083 -> illegal = 0.
  - R-type with funct7 = 0x01 (MUL) -> illegal = 1.
